rsa_modexp_ctrl: RTL

//  Sequencer for RSA modular exponentiation (left-to-right square-and-multiply).

---
 rtl/rsa_modexp_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for RSA modular exponentiation.
// Drives a shared modular multiplier over a req/done handshake; holds no operand data.
module rsa_modexp_ctrl #(
  parameter int EXP_W = 32,
  parameter int IDX_W = $clog2(EXP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] exp,
  output logic             mm_req,
  output logic             mm_sel,
  input  logic             mm_done,
  output logic             load_one,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_SCAN = 3'd2,
    S_SQR  = 3'd3,
    S_MUL  = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_r;
  state_t             next_state_s;
  logic               start_d_r;
  logic [EXP_W-1:0]   exp_q_r;
  logic [EXP_W-1:0]   exp_q_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic               launch_s;
  logic               cur_bit_s;
  logic               idx_zero_s;

  logic               mm_req_s, mm_sel_s, load_one_s, busy_s, done_s;
  logic               mm_req_r, mm_sel_r, load_one_r, busy_r, done_r;

  assign launch_s   = start & ~start_d_r;
  assign cur_bit_s  = exp_q_r[idx_r];
  assign idx_zero_s = (idx_r == IDX_ZERO);

  // Start history for the rising-edge detector, sampled every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_d_r <= 1'b0;
    end else begin
      start_d_r <= start;
    end
  end

  // State, latched exponent and bit index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      exp_q_r <= {EXP_W{1'b0}};
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= next_state_s;
      exp_q_r <= exp_q_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE, including mm_done.
  always_comb begin
    next_state_s = state_r;
    exp_q_nxt_s  = exp_q_r;
    idx_nxt_s    = idx_r;
    if ((state_r != S_IDLE) && abort) begin
      next_state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (launch_s) begin
            next_state_s = S_INIT;
            exp_q_nxt_s  = exp;
            idx_nxt_s    = IDX_MSB;
          end else begin
            next_state_s = S_IDLE;
          end
        end
        S_INIT: next_state_s = S_SCAN;
        S_SCAN: begin
          // Leading zeros are skipped without touching the multiplier.
          if (cur_bit_s) begin
            next_state_s = S_SQR;
          end else if (idx_zero_s) begin
            next_state_s = S_DONE;
          end else begin
            idx_nxt_s = idx_r - IDX_ONE;
          end
        end
        S_SQR: begin
          if (mm_done) begin
            next_state_s = cur_bit_s ? S_MUL : S_NEXT;
          end else begin
            next_state_s = S_SQR;
          end
        end
        S_MUL: begin
          if (mm_done) begin
            next_state_s = S_NEXT;
          end else begin
            next_state_s = S_MUL;
          end
        end
        S_NEXT: begin
          if (idx_zero_s) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_SQR;
            idx_nxt_s    = idx_r - IDX_ONE;
          end
        end
        S_DONE:  next_state_s = S_IDLE;
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track state_r.
  always_comb begin
    mm_req_s   = 1'b0;
    mm_sel_s   = 1'b0;
    load_one_s = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    case (next_state_s)
      S_IDLE:  busy_s     = 1'b0;
      S_INIT:  load_one_s = 1'b1;
      S_SCAN:  busy_s     = 1'b1;
      S_SQR:   mm_req_s   = 1'b1;
      S_MUL: begin
        mm_req_s = 1'b1;
        mm_sel_s = 1'b1;
      end
      S_NEXT:  busy_s     = 1'b1;
      S_DONE:  done_s     = 1'b1;
      default: busy_s     = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mm_req_r   <= 1'b0;
      mm_sel_r   <= 1'b0;
      load_one_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mm_req_r   <= mm_req_s;
      mm_sel_r   <= mm_sel_s;
      load_one_r <= load_one_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign mm_req   = mm_req_r;
  assign mm_sel   = mm_sel_r;
  assign load_one = load_one_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign bit_idx  = idx_r;

endmodule
